nn_result_display: RTL and testbench

- Parametrised front-panel controller between the board inputs, the neural_network core and the seven-segment bank.
- Detects start-button presses and issues a single-cycle start to the core.
- Runs a busy animation while inference is running, enforces a timeout, and latches each argmax result into a multi-digit history display.
- Replaces the free-running divided clock with a clock-enable tick, so everything runs on one clock.

---
 rtl/nn_result_display.sv | 174 +++++++++++++++++
 tb/tb_nn_result_display.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_result_display.sv
// Front-panel controller: start-button edge detect, busy animation with timeout, argmax digit display.
// Define NN_DISPLAY_HISTORY_EN to scroll previous results through digits 1..NUM_DIGITS-1.
module nn_result_display #(
    parameter int NUM_DIGITS    = 4,
    parameter int CLASS_W       = 4,
    parameter int NUM_CLASSES   = 10,
    parameter int TICK_DIV      = 500,
    parameter int TIMEOUT_TICKS = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    key_n,
    input  logic                    nn_done,
    input  logic [CLASS_W-1:0]      argmax_in,
    output logic                    nn_start,
    output logic                    busy,
    output logic                    error,
    output logic [7:0]              result_count,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ERR   = 7'h06;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    logic [2:0]        key_sync_q, key_sync_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [2:0]        anim_q, anim_d;
    logic [1:0]        state_q, state_d;
    logic              start_q, start_d;
    logic              err_q, err_d;
    logic [7:0]        count_q, count_d;
    logic [6:0]        digit_q [NUM_DIGITS];
    logic [6:0]        digit_d [NUM_DIGITS];

    logic       press;
    logic       tick;
    logic       bad_class;
    logic       complete;
    logic [6:0] result_seg;
    logic [6:0] new_seg;
    logic [6:0] anim_seg;

    // Bit 2 holds the previous synchronised sample, so a press is old=1, new=0.
    assign press = key_sync_q[2] & ~key_sync_q[1];
    assign tick  = (tick_cnt_q == TICK_W'(TICK_DIV - 1));

    always_comb begin
        bad_class  = (32'(argmax_in) >= 32'(NUM_CLASSES));
        result_seg = SEG_ERR;
        if (!bad_class) begin
            case (32'(argmax_in))
                32'd0:   result_seg = 7'h40;
                32'd1:   result_seg = 7'h79;
                32'd2:   result_seg = 7'h24;
                32'd3:   result_seg = 7'h30;
                32'd4:   result_seg = 7'h19;
                32'd5:   result_seg = 7'h12;
                32'd6:   result_seg = 7'h02;
                32'd7:   result_seg = 7'h78;
                32'd8:   result_seg = 7'h00;
                32'd9:   result_seg = 7'h10;
                default: result_seg = SEG_ERR;
            endcase
        end
    end

    always_comb begin
        key_sync_d = {key_sync_q[1:0], key_n};
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        to_cnt_d   = to_cnt_q;
        anim_d     = anim_q;
        state_d    = state_q;
        start_d    = 1'b0;
        err_d      = err_q;
        count_d    = count_q;
        digit_d    = digit_q;
        complete   = 1'b0;
        new_seg    = SEG_BLANK;

        case (state_q)
            ST_RUN: begin
                // A completion beats a timeout landing in the same cycle.
                if (nn_done) begin
                    complete = 1'b1;
                    new_seg  = result_seg;
                    err_d    = err_q | bad_class;
                    count_d  = count_q + 8'd1;
                    state_d  = ST_SHOW;
                end else if (tick) begin
                    anim_d   = (anim_q == 3'd5) ? 3'd0 : anim_q + 3'd1;
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_q == TO_W'(TIMEOUT_TICKS - 1)) begin
                        complete = 1'b1;
                        new_seg  = SEG_DASH;
                        err_d    = 1'b1;
                        state_d  = ST_SHOW;
                    end
                end
            end
            default: begin
                if (press) begin
                    start_d  = 1'b1;
                    state_d  = ST_RUN;
                    to_cnt_d = '0;
                    anim_d   = 3'd0;
                    err_d    = 1'b0;
                end
            end
        endcase

        if (complete) begin
`ifdef NN_DISPLAY_HISTORY_EN
            for (int i = NUM_DIGITS - 1; i > 0; i--) begin
                digit_d[i] = digit_q[i-1];
            end
`endif
            digit_d[0] = new_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_sync_q <= 3'b111;
            tick_cnt_q <= '0;
            to_cnt_q   <= '0;
            anim_q     <= 3'd0;
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= 8'd0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= SEG_BLANK;
            end
        end else begin
            key_sync_q <= key_sync_d;
            tick_cnt_q <= tick_cnt_d;
            to_cnt_q   <= to_cnt_d;
            anim_q     <= anim_d;
            state_q    <= state_d;
            start_q    <= start_d;
            err_q      <= err_d;
            count_q    <= count_d;
            digit_q    <= digit_d;
        end
    end

    // While running, digit 0 shows the spinner instead of the last stored result.
    assign anim_seg = ~(7'd1 << anim_q);

    always_comb begin
        hex_out = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            hex_out[7*i +: 7] = digit_q[i];
        end
        if (state_q == ST_RUN) begin
            hex_out[6:0] = anim_seg;
        end
    end

    assign nn_start     = start_q;
    assign busy         = (state_q == ST_RUN);
    assign error        = err_q;
    assign result_count = count_q;

endmodule

// File: tb/tb_nn_result_display.sv
// Randomised bench for nn_result_display with a queue-based display model.
// Follows NN_DISPLAY_HISTORY_EN the same way as the design.
module tb_nn_result_display;

    localparam int ND = 4;
    localparam int TD = 4;
    localparam int TO = 8;
    localparam int NC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_n;
    logic        nn_done;
    logic [3:0]  argmax_in;
    logic        nn_start;
    logic        busy;
    logic        error;
    logic [7:0]  result_count;
    logic [27:0] hex_out;

    always #5 clk = ~clk;

    nn_result_display #(
        .NUM_DIGITS(ND), .CLASS_W(4), .NUM_CLASSES(NC), .TICK_DIV(TD), .TIMEOUT_TICKS(TO)
    ) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .nn_done(nn_done), .argmax_in(argmax_in),
        .nn_start(nn_start), .busy(busy), .error(error), .result_count(result_count),
        .hex_out(hex_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit checks_on = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 showing; results kept newest-first.
    int       seg_lut [10] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78, 'h00, 'h10};
    int       m_state = 0;
    bit       m_start = 0;
    bit       m_err   = 0;
    int       m_count = 0;
    int       m_ticks = 0;
    int       m_cyc   = 0;
    bit [2:0] m_key   = 3'b111;
    int       hist [$];

    function automatic void pushCode(input int c);
        hist.push_front(c);
`ifdef NN_DISPLAY_HISTORY_EN
        if (hist.size() > ND) void'(hist.pop_back());
`else
        while (hist.size() > 1) void'(hist.pop_back());
`endif
    endfunction

    function automatic logic [27:0] expHex();
        logic [27:0] r;
        int v;
        r = '1;
        for (int i = 0; i < ND; i++) begin
            if (i == 0 && m_state == 1) v = 127 - (1 << (m_ticks % 6));
            else if (i < hist.size()) v = hist[i];
            else v = 127;
            r[7*i +: 7] = v[6:0];
        end
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit press;
        bit tick;
        int a;
        if (reset) begin
            m_state = 0; m_start = 0; m_err = 0; m_count = 0; m_ticks = 0; m_cyc = 0;
            m_key = 3'b111;
            hist.delete();
        end else begin
            press = m_key[2] && !m_key[1];
            tick  = (m_cyc % TD) == TD - 1;
            m_start = 0;
            if (m_state == 1) begin
                if (nn_done) begin
                    a = int'(argmax_in);
                    pushCode(a < NC ? seg_lut[a] : 'h06);
                    if (a >= NC) m_err = 1;
                    m_count = (m_count + 1) % 256;
                    m_state = 2;
                end else if (tick) begin
                    m_ticks++;
                    if (m_ticks == TO) begin
                        pushCode('h3F);
                        m_err = 1;
                        m_state = 2;
                    end
                end
            end else if (press) begin
                m_start = 1; m_state = 1; m_ticks = 0; m_err = 0;
            end
            m_key = {m_key[1:0], key_n};
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (checks_on) begin
            checkOutput("nn_start", 32'(nn_start), 32'(m_start));
            checkOutput("busy", 32'(busy), 32'(m_state == 1));
            checkOutput("error", 32'(error), 32'(m_err));
            checkOutput("result_count", 32'(result_count), 32'(m_count));
            checkOutput("hex_out", 32'(hex_out), 32'(expHex()));
        end
    end

    // Inputs are applied at a falling edge; the task returns at the next falling edge.
    task automatic applyStimulus(input logic k, input logic d, input logic [3:0] a);
        key_n = k; nn_done = d; argmax_in = a;
        @(negedge clk);
    endtask

    task automatic startRun();
        int n;
        n = 0;
        applyStimulus(1'b0, 1'b0, 4'd0);
        while (busy !== 1'b1 && n < 12) begin
            applyStimulus(1'b0, 1'b0, 4'd0);
            n++;
        end
        if (busy !== 1'b1) checkOutput("start_wait", 32'(busy), 32'd1);
    endtask

    task automatic runOnce(input logic [3:0] arg, input int delay, input bit noisy);
        startRun();
        repeat (delay) applyStimulus(noisy ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, arg);
        repeat (4) applyStimulus(1'b1, noisy ? 1'($urandom_range(0, 1)) : 1'b0,
                                 4'($urandom_range(0, 15)));
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd0);
        reset = 1'b0;
        repeat (3) applyStimulus(1'b1, 1'b0, 4'd0);
    endtask

    logic [6:0]  anim_exp [7] = '{7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F, 7'h7E};
    logic [27:0] hist_exp;

    initial begin
        int first_k;
        int pulses;
        int n;
        int idx;

        // Reset with the key held low, key released before reset drops.
        reset = 1'b1;
        repeat (4) applyStimulus(1'b0, 1'b0, 4'd0);
        checks_on = 1'b1;
        repeat (2) applyStimulus(1'b1, 1'b0, 4'd0);
        reset = 1'b0;
        repeat (6) applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("reset_hex", 32'(hex_out), 32'h0FFFFFFF);
        checkOutput("reset_count", 32'(result_count), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);

        // Press latency and single pulse while the key stays low.
        first_k = -1;
        pulses  = 0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, 1'b0, 4'd0);
            if (nn_start === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        checkOutput("start_latency", 32'(first_k), 32'd3);
        applyStimulus(1'b0, 1'b1, 4'd7);
        checkOutput("done7_digit0", 32'(hex_out[6:0]), 32'h78);
        checkOutput("done7_busy", 32'(busy), 32'd0);
        checkOutput("done7_count", 32'(result_count), 32'd1);
        repeat (8) begin
            applyStimulus(1'b0, 1'b0, 4'd0);
            if (nn_start === 1'b1) pulses++;
        end
        checkOutput("single_pulse", 32'(pulses), 32'd1);
        repeat (4) applyStimulus(1'b1, 1'b0, 4'd0);

        // History with an invalid class.
        pulseReset();
        runOnce(4'd3, 5, 1'b0);
        runOnce(4'd9, 5, 1'b0);
        runOnce(4'd12, 5, 1'b0);
`ifdef NN_DISPLAY_HISTORY_EN
        hist_exp = {7'h7F, 7'h30, 7'h10, 7'h06};
`else
        hist_exp = {7'h7F, 7'h7F, 7'h7F, 7'h06};
`endif
        checkOutput("history_hex", 32'(hex_out), 32'(hist_exp));
        checkOutput("history_error", 32'(error), 32'd1);

        // Next press clears the error, then let it time out.
        startRun();
        checkOutput("error_cleared", 32'(error), 32'd0);
        repeat (40) applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("timeout_digit0", 32'(hex_out[6:0]), 32'h3F);
        checkOutput("timeout_error", 32'(error), 32'd1);
        checkOutput("timeout_count", 32'(result_count), 32'd3);
        applyStimulus(1'b1, 1'b1, 4'd5);
        applyStimulus(1'b1, 1'b0, 4'd0);
        checkOutput("late_done_ignored", 32'(hex_out[6:0]), 32'h3F);
        checkOutput("late_done_count", 32'(result_count), 32'd3);
        repeat (3) applyStimulus(1'b1, 1'b0, 4'd0);

        // Done landing on the timeout tick.
        startRun();
        n = 0;
        while (!(m_state == 1 && m_ticks == TO - 1 && (m_cyc % TD) == TD - 1) && n < 100) begin
            applyStimulus(1'b1, 1'b0, 4'd0);
            n++;
        end
        applyStimulus(1'b1, 1'b1, 4'd2);
        checkOutput("tie_digit0", 32'(hex_out[6:0]), 32'h24);
        checkOutput("tie_error", 32'(error), 32'd0);
        checkOutput("tie_count", 32'(result_count), 32'd4);
        repeat (3) applyStimulus(1'b1, 1'b0, 4'd0);

        // Spinner sampled on each tick, then reset mid-run.
        startRun();
        idx = 0;
        n = 0;
        while (idx < 7 && n < 60) begin
            if (m_state == 1 && (m_cyc % TD) == TD - 1) begin
                checkOutput("anim_step", 32'(hex_out[6:0]), 32'(anim_exp[idx]));
                idx++;
            end
            if (idx < 7) applyStimulus(1'b1, 1'b0, 4'd0);
            n++;
        end
        if (idx != 7) checkOutput("anim_ticks", 32'(idx), 32'd7);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd0);
        reset = 1'b0;
        checkOutput("midrun_reset_busy", 32'(busy), 32'd0);
        checkOutput("midrun_reset_hex", 32'(hex_out), 32'h0FFFFFFF);
        repeat (3) applyStimulus(1'b1, 1'b0, 4'd0);

        // Random runs with key noise, stray done pulses and occasional timeouts.
        repeat (200) runOnce(4'($urandom_range(0, 15)), $urandom_range(0, 45), 1'b1);

        // Count wrap after 256 completed runs.
        pulseReset();
        repeat (256) runOnce(4'($urandom_range(0, 15)), $urandom_range(0, 10), 1'b0);
        checkOutput("count_wrap", 32'(result_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
